sr_ff_consistency_monitor: RTL and testbench

//  Downstream checker for the SR flip-flop block: samples S/R and the three Q outputs (JK-, D-, T-based),

---
 rtl/sr_ff_pkg.sv | 23 ++
 rtl/sr_golden_model.sv | 48 ++++
 rtl/sr_ff_consistency_monitor.sv | 149 ++++++++++++++
 tb/tb_sr_ff_consistency_monitor.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_ff_pkg.sv
// Shared definitions for the SR flip-flop block, its consistency monitor and bench.
// Holds the monitor FSM states and the S/R input encodings.
package sr_ff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_RST  = 2'b01;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_BAD  = 2'b11;

    localparam int NUM_LANES = 3;

    function automatic logic [1:0] srCode(input logic s, input logic r);
        return {s, r};
    endfunction

endpackage

// File: rtl/sr_golden_model.sv
// Reference SR flip-flop: tracks the expected Q and whether it is currently defined.
// An S1R1 request makes Q unknown until the next explicit set or reset.
module sr_golden_model
    import sr_ff_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic s_i,
    input  logic r_i,
    output logic expQ_o,
    output logic expKnown_o
);

    logic expQ_q, expQ_d;
    logic expKnown_q, expKnown_d;

    always_comb begin
        expQ_d     = expQ_q;
        expKnown_d = expKnown_q;
        case (srCode(s_i, r_i))
            SR_RST: begin
                expQ_d     = 1'b0;
                expKnown_d = 1'b1;
            end
            SR_SET: begin
                expQ_d     = 1'b1;
                expKnown_d = 1'b1;
            end
            SR_BAD:  expKnown_d = 1'b0;
            default: ;
        endcase
    end

    // Reset value matches the flop's own reset (Q=0), so the model is defined from the start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            expQ_q     <= 1'b0;
            expKnown_q <= 1'b1;
        end else begin
            expQ_q     <= expQ_d;
            expKnown_q <= expKnown_d;
        end
    end

    assign expQ_o     = expQ_q;
    assign expKnown_o = expKnown_q;

endmodule

// File: rtl/sr_ff_consistency_monitor.sv
// Passive checker comparing the JK-, D- and T-based SR flip-flop outputs against a golden model.
// Lane 0 = JK variant, lane 1 = D variant, lane 2 = T variant.
module sr_ff_consistency_monitor
    import sr_ff_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int CYC_W        = 16,
    parameter int RUN_CYCLES   = 64,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             s_i,
    input  logic             r_i,
    input  logic             q_jk_i,
    input  logic             q_d_i,
    input  logic             q_t_i,
    output logic             err_jk_o,
    output logic             err_d_o,
    output logic             err_t_o,
    output logic [CNT_W-1:0] cnt_jk_o,
    output logic [CNT_W-1:0] cnt_d_o,
    output logic [CNT_W-1:0] cnt_t_o,
    output logic [CYC_W-1:0] cyc_cnt_o,
    output logic [CYC_W-1:0] first_fail_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CYC_W-1:0] CYC_MAX     = '1;
    localparam logic [CYC_W-1:0] LAST_CYC    = CYC_W'(RUN_CYCLES - 1);
    localparam bit               RUN_BOUNDED = (RUN_CYCLES != 0);
    localparam bit               STOP_EN     = (STOP_ON_FAIL != 0);

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cycCnt_q, cycCnt_d;
    logic [CYC_W-1:0]   firstFail_q, firstFail_d;
    logic               expQ, expKnown;
    logic               active;
    logic [NUM_LANES-1:0] qVec;
    logic [NUM_LANES-1:0] mismatch;
    logic [NUM_LANES-1:0] errVec;
    logic [CNT_W-1:0]   cntVec [NUM_LANES];
    logic               anyMismatch;

    sr_golden_model uGolden (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .s_i        (s_i),
        .r_i        (r_i),
        .expQ_o     (expQ),
        .expKnown_o (expKnown)
    );

    assign qVec        = {q_t_i, q_d_i, q_jk_i};
    assign active      = (state_q == ST_RUN) && en_i;
    assign anyMismatch = |mismatch;

    // Q registered before this edge is compared with the model state from the same prior edge.
    for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
        logic             errFlag_q;
        logic [CNT_W-1:0] cnt_q;

        assign mismatch[i] = active && expKnown && (qVec[i] != expQ);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                errFlag_q <= 1'b0;
                cnt_q     <= '0;
            end else if (clr_i) begin
                errFlag_q <= 1'b0;
                cnt_q     <= '0;
            end else if (mismatch[i]) begin
                errFlag_q <= 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign errVec[i] = errFlag_q;
        assign cntVec[i] = cnt_q;
    end

    // A halting edge records the mismatch but leaves the cycle count on the failing cycle.
    always_comb begin
        state_d     = state_q;
        cycCnt_d    = cycCnt_q;
        firstFail_d = firstFail_q;
        if (clr_i) begin
            state_d     = ST_IDLE;
            cycCnt_d    = '0;
            firstFail_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (en_i) state_d = ST_RUN;
                ST_RUN: begin
                    if (!en_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (anyMismatch && !(|errVec)) begin
                            firstFail_d = cycCnt_q;
                        end
                        if (anyMismatch && STOP_EN) begin
                            state_d = ST_HALT;
                        end else begin
                            if (cycCnt_q != CYC_MAX) begin
                                cycCnt_d = cycCnt_q + CYC_W'(1);
                            end
                            if (RUN_BOUNDED && (cycCnt_q == LAST_CYC)) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cycCnt_q    <= '0;
            firstFail_q <= '0;
        end else begin
            state_q     <= state_d;
            cycCnt_q    <= cycCnt_d;
            firstFail_q <= firstFail_d;
        end
    end

    assign err_jk_o     = errVec[0];
    assign err_d_o      = errVec[1];
    assign err_t_o      = errVec[2];
    assign cnt_jk_o     = cntVec[0];
    assign cnt_d_o      = cntVec[1];
    assign cnt_t_o      = cntVec[2];
    assign cyc_cnt_o    = cycCnt_q;
    assign first_fail_o = firstFail_q;
    assign busy_o       = (state_q == ST_RUN);
    assign done_o       = (state_q == ST_DONE) || (state_q == ST_HALT);
    assign pass_o       = done_o && !(|errVec);

endmodule

// File: tb/tb_sr_ff_consistency_monitor.sv
// Scoreboard bench: three monitor configurations share one stimulus stream and a behavioural model.
// Instance 0: RUN_CYCLES=8; instance 1: STOP_ON_FAIL=1; instance 2: CNT_W=2, unbounded run.
module tb_sr_ff_consistency_monitor;
    import sr_ff_pkg::*;

    typedef struct {
        int          dut;
        logic [63:0] exp;
    } sbEntry_t;

    logic clk = 1'b0;
    logic rst, en, clr, s, r, qJk, qD, qT;
    logic flopQ;

    logic        errJk [3];
    logic        errD  [3];
    logic        errT  [3];
    logic [7:0]  cntJk [3];
    logic [7:0]  cntD  [3];
    logic [7:0]  cntT  [3];
    logic [1:0]  cntJkC, cntDC, cntTC;
    logic [15:0] cycCnt    [3];
    logic [15:0] firstFail [3];
    logic        busy [3];
    logic        done [3];
    logic        pass [3];

    state_e mSt    [3];
    bit     mExpQ  [3];
    bit     mKnown [3];
    int     mCnt   [3][3];
    bit     mErr   [3][3];
    int     mCyc   [3];
    int     mFf    [3];
    int     pMax   [3] = '{255, 255, 3};
    int     pRun   [3] = '{8, 0, 0};
    bit     pStop  [3] = '{1'b0, 1'b1, 1'b0};

    sbEntry_t sbQ [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign cntJk[2] = {6'b0, cntJkC};
    assign cntD[2]  = {6'b0, cntDC};
    assign cntT[2]  = {6'b0, cntTC};

    sr_ff_consistency_monitor #(.CNT_W(8), .CYC_W(16), .RUN_CYCLES(8), .STOP_ON_FAIL(0)) uDutA (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .s_i(s), .r_i(r),
        .q_jk_i(qJk), .q_d_i(qD), .q_t_i(qT),
        .err_jk_o(errJk[0]), .err_d_o(errD[0]), .err_t_o(errT[0]),
        .cnt_jk_o(cntJk[0]), .cnt_d_o(cntD[0]), .cnt_t_o(cntT[0]),
        .cyc_cnt_o(cycCnt[0]), .first_fail_o(firstFail[0]),
        .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0])
    );

    sr_ff_consistency_monitor #(.CNT_W(8), .CYC_W(16), .RUN_CYCLES(0), .STOP_ON_FAIL(1)) uDutB (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .s_i(s), .r_i(r),
        .q_jk_i(qJk), .q_d_i(qD), .q_t_i(qT),
        .err_jk_o(errJk[1]), .err_d_o(errD[1]), .err_t_o(errT[1]),
        .cnt_jk_o(cntJk[1]), .cnt_d_o(cntD[1]), .cnt_t_o(cntT[1]),
        .cyc_cnt_o(cycCnt[1]), .first_fail_o(firstFail[1]),
        .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1])
    );

    sr_ff_consistency_monitor #(.CNT_W(2), .CYC_W(16), .RUN_CYCLES(0), .STOP_ON_FAIL(0)) uDutC (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .s_i(s), .r_i(r),
        .q_jk_i(qJk), .q_d_i(qD), .q_t_i(qT),
        .err_jk_o(errJk[2]), .err_d_o(errD[2]), .err_t_o(errT[2]),
        .cnt_jk_o(cntJkC), .cnt_d_o(cntDC), .cnt_t_o(cntTC),
        .cyc_cnt_o(cycCnt[2]), .first_fail_o(firstFail[2]),
        .busy_o(busy[2]), .done_o(done[2]), .pass_o(pass[2])
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observed(input int i);
        return {1'b0, errJk[i], errD[i], errT[i], cntJk[i], cntD[i], cntT[i],
                cycCnt[i], firstFail[i], busy[i], done[i], pass[i]};
    endfunction

    function automatic logic [63:0] modelOut(input int i);
        bit dn, anyE;
        dn   = (mSt[i] == ST_DONE) || (mSt[i] == ST_HALT);
        anyE = mErr[i][0] | mErr[i][1] | mErr[i][2];
        return {1'b0, mErr[i][0], mErr[i][1], mErr[i][2],
                8'(mCnt[i][0]), 8'(mCnt[i][1]), 8'(mCnt[i][2]),
                16'(mCyc[i]), 16'(mFf[i]), (mSt[i] == ST_RUN), dn, dn && !anyE};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            mSt[i] = ST_IDLE; mExpQ[i] = 1'b0; mKnown[i] = 1'b1;
            mCyc[i] = 0; mFf[i] = 0;
            for (int k = 0; k < 3; k++) begin
                mCnt[i][k] = 0; mErr[i][k] = 1'b0;
            end
        end
    endtask

    task automatic modelStep(input int i, input bit e, input bit c, input logic [1:0] sr, input bit [2:0] qv);
        bit mis [3];
        bit anyMis, hadErr;
        int oldCyc;
        anyMis = 1'b0;
        hadErr = mErr[i][0] | mErr[i][1] | mErr[i][2];
        for (int k = 0; k < 3; k++) begin
            mis[k] = (mSt[i] == ST_RUN) && e && mKnown[i] && (qv[k] != mExpQ[i]);
            anyMis |= mis[k];
        end
        case (sr)
            SR_RST: begin mExpQ[i] = 1'b0; mKnown[i] = 1'b1; end
            SR_SET: begin mExpQ[i] = 1'b1; mKnown[i] = 1'b1; end
            SR_BAD: mKnown[i] = 1'b0;
            default: ;
        endcase
        if (c) begin
            mSt[i] = ST_IDLE; mCyc[i] = 0; mFf[i] = 0;
            for (int k = 0; k < 3; k++) begin
                mCnt[i][k] = 0; mErr[i][k] = 1'b0;
            end
        end else if (mSt[i] == ST_IDLE) begin
            if (e) mSt[i] = ST_RUN;
        end else if (mSt[i] == ST_RUN) begin
            if (!e) begin
                mSt[i] = ST_IDLE;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (mis[k]) begin
                        mErr[i][k] = 1'b1;
                        if (mCnt[i][k] < pMax[i]) mCnt[i][k]++;
                    end
                end
                if (anyMis && !hadErr) mFf[i] = mCyc[i];
                if (anyMis && pStop[i]) begin
                    mSt[i] = ST_HALT;
                end else begin
                    oldCyc = mCyc[i];
                    if (mCyc[i] < 65535) mCyc[i]++;
                    if (pRun[i] != 0 && oldCyc == pRun[i] - 1) mSt[i] = ST_DONE;
                end
            end
        end
    endtask

    // One clock of stimulus; f inverts the {t,d,jk} outputs of an otherwise correct flop.
    task automatic applyStimulus(input bit e, input bit c, input logic [1:0] sr, input bit [2:0] f);
        sbEntry_t ent;
        @(negedge clk);
        en = e; clr = c; s = sr[1]; r = sr[0];
        qJk = flopQ ^ f[0]; qD = flopQ ^ f[1]; qT = flopQ ^ f[2];
        for (int i = 0; i < 3; i++) begin
            modelStep(i, e, c, sr, {qT, qD, qJk});
            sbQ.push_back('{i, modelOut(i)});
        end
        @(posedge clk);
        #1;
        case (sr)
            SR_RST:  flopQ = 1'b0;
            SR_SET:  flopQ = 1'b1;
            SR_BAD:  flopQ = 1'($urandom_range(0, 1));
            default: ;
        endcase
        while (sbQ.size() > 0) begin
            ent = sbQ.pop_front();
            checkOutput($sformatf("cycle_dut%0d", ent.dut), observed(ent.dut), ent.exp);
        end
    endtask

    initial begin
        logic [1:0] pattern [4];
        pattern[0] = SR_HOLD; pattern[1] = SR_RST; pattern[2] = SR_SET; pattern[3] = SR_BAD;
        rst = 1'b1; en = 1'b0; clr = 1'b0; s = 1'b0; r = 1'b0;
        qJk = 1'b0; qD = 1'b0; qT = 1'b0; flopQ = 1'b0;
        modelReset();
        #12;
        for (int i = 0; i < 3; i++) checkOutput($sformatf("reset_dut%0d", i), observed(i), 64'd0);
        rst = 1'b0;

        // clean run through all four S/R codes; instance 0 finishes after 8 checked cycles
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b000);
        for (int k = 0; k < 11; k++) applyStimulus(1'b1, 1'b0, pattern[k % 4], 3'b000);
        checkOutput("t1_doneA", 64'(done[0]), 64'd1);
        checkOutput("t1_passA", 64'(pass[0]), 64'd1);
        checkOutput("t1_cycA", 64'(cycCnt[0]), 64'd8);
        checkOutput("t1_busyA", 64'(busy[0]), 64'd0);
        checkOutput("t1_cntA", {40'd0, cntJk[0], cntD[0], cntT[0]}, 64'd0);
        applyStimulus(1'b0, 1'b1, SR_HOLD, 3'b000);
        checkOutput("t1_clrA", observed(0), 64'd0);

        // single-cycle T fault right after a set
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_RST, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_SET, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b100);
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b000);
        checkOutput("t2_errTA", 64'(errT[0]), 64'd1);
        checkOutput("t2_cntTA", 64'(cntT[0]), 64'd1);
        checkOutput("t2_firstFailA", 64'(firstFail[0]), 64'd2);
        checkOutput("t2_errJkDA", {62'd0, errJk[0], errD[0]}, 64'd0);
        checkOutput("t2_passA", {62'd0, done[0], pass[0]}, 64'd2);
        applyStimulus(1'b0, 1'b1, SR_HOLD, 3'b000);

        // invalid S1R1 suspends checking until the next explicit reset
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_RST, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_BAD, 3'b000);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, SR_HOLD, 3'($urandom_range(0, 7)));
        applyStimulus(1'b1, 1'b0, SR_RST, 3'($urandom_range(0, 7)));
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b010);
        checkOutput("t3_errDA", 64'(errD[0]), 64'd1);
        checkOutput("t3_cntDA", 64'(cntD[0]), 64'd1);
        checkOutput("t3_othersA", {62'd0, errJk[0], errT[0]}, 64'd0);
        checkOutput("t3_firstFailA", 64'(firstFail[0]), 64'd6);
        applyStimulus(1'b0, 1'b1, SR_HOLD, 3'b000);

        // stop-on-fail instance halts on a JK fault at cycle 5
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_SET, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_RST, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_SET, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b001);
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b000);
        checkOutput("t4_cycB", 64'(cycCnt[1]), 64'd5);
        checkOutput("t4_firstFailB", 64'(firstFail[1]), 64'd5);
        checkOutput("t4_doneB", 64'(done[1]), 64'd1);
        checkOutput("t4_busyB", 64'(busy[1]), 64'd0);
        checkOutput("t4_passB", 64'(pass[1]), 64'd0);
        applyStimulus(1'b0, 1'b1, SR_HOLD, 3'b000);
        checkOutput("t4_clrB", observed(1), 64'd0);

        // narrow counter saturates under a persistent D fault
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_RST, 3'b000);
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b010);
        checkOutput("t5_cntDC", 64'(cntDC), 64'd3);
        checkOutput("t5_errDC", 64'(errD[2]), 64'd1);
        applyStimulus(1'b0, 1'b1, SR_HOLD, 3'b000);

        // asynchronous reset between edges in the middle of a run
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_SET, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_RST, 3'b000);
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b000);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) checkOutput($sformatf("t6_rst_dut%0d", i), observed(i), 64'd0);
        modelReset();
        flopQ = 1'b0;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, SR_HOLD, 3'b000);
        for (int k = 0; k < 9; k++) applyStimulus(1'b1, 1'b0, pattern[(k + 1) % 4], 3'b000);
        checkOutput("t6_rerunA", {62'd0, done[0], pass[0]}, 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
